// File: rtl/tlc_pkg.sv
// Shared encodings and default timings for the traffic light controller.
// Optional pedestrian support is controlled by the TLC_PED_WALK_EN macro.
package tlc_pkg;

  typedef enum logic [2:0] {
    MAIN_G = 3'd0,
    MAIN_Y = 3'd1,
    RED_1  = 3'd2,
    SIDE_G = 3'd3,
    SIDE_Y = 3'd4,
    RED_2  = 3'd5
  } tlc_state_e;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  localparam int unsigned GREEN_MIN_DEF    = 8;
  localparam int unsigned YELLOW_T_DEF     = 3;
  localparam int unsigned ALL_RED_T_DEF    = 1;
  localparam int unsigned SIDE_GREEN_T_DEF = 5;
  localparam int unsigned CNT_W_DEF        = 8;

endpackage

// File: rtl/sensor_sync.sv
// Two-flop synchroniser for an asynchronous sensor line; both stages reset to 0.
module sensor_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-road intersection sequencer: six-state FSM with a saturating phase timer.
// Define TLC_PED_WALK_EN to add the ped_btn input and ped_walk output.
module traffic_light_ctrl
  import tlc_pkg::*;
#(
  parameter int unsigned GREEN_MIN    = GREEN_MIN_DEF,
  parameter int unsigned YELLOW_T     = YELLOW_T_DEF,
  parameter int unsigned ALL_RED_T    = ALL_RED_T_DEF,
  parameter int unsigned SIDE_GREEN_T = SIDE_GREEN_T_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       side_car,
`ifdef TLC_PED_WALK_EN
  input  logic       ped_btn,
  output logic       ped_walk,
`endif
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic [2:0] phase
);

  tlc_state_e       state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             side_req_q, side_req_d;
  logic             side_sync;
  logic             enter_side_g;
  logic             any_req;

  function automatic logic [CNT_W-1:0] load_for(input tlc_state_e s);
    case (s)
      MAIN_Y, SIDE_Y: return CNT_W'(YELLOW_T - 1);
      RED_1, RED_2:   return CNT_W'(ALL_RED_T - 1);
      SIDE_G:         return CNT_W'(SIDE_GREEN_T - 1);
      default:        return CNT_W'(GREEN_MIN - 1);
    endcase
  endfunction

  sensor_sync u_side_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .async_i(side_car),
    .sync_o (side_sync)
  );

`ifdef TLC_PED_WALK_EN
  logic ped_sync;
  logic ped_req_q;

  sensor_sync u_ped_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .async_i(ped_btn),
    .sync_o (ped_sync)
  );

  always_ff @(posedge clk) begin
    if (!rst_n)            ped_req_q <= 1'b0;
    else if (enter_side_g) ped_req_q <= 1'b0;
    else if (ped_sync)     ped_req_q <= 1'b1;
  end

  assign any_req  = side_req_q | ped_req_q;
  assign ped_walk = (state_q == SIDE_G);
`else
  assign any_req = side_req_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= MAIN_G;
      timer_q    <= CNT_W'(GREEN_MIN - 1);
      side_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      side_req_q <= side_req_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = (timer_q == '0) ? '0 : timer_q - CNT_W'(1);
    case (state_q)
      MAIN_G:  if (timer_q == '0 && any_req) state_d = MAIN_Y;
      MAIN_Y:  if (timer_q == '0) state_d = RED_1;
      RED_1:   if (timer_q == '0) state_d = SIDE_G;
      SIDE_G:  if (timer_q == '0) state_d = SIDE_Y;
      SIDE_Y:  if (timer_q == '0) state_d = RED_2;
      RED_2:   if (timer_q == '0) state_d = MAIN_G;
      default: state_d = MAIN_G;
    endcase
    // Any state change, including recovery from an illegal encoding, reloads the timer.
    if (state_d != state_q) timer_d = load_for(state_d);
    enter_side_g = (state_d == SIDE_G) && (state_q != SIDE_G);
    side_req_d   = enter_side_g ? 1'b0 : (side_req_q | side_sync);
  end

  always_comb begin
    main_light = LAMP_R;
    side_light = LAMP_R;
    case (state_q)
      MAIN_G:  main_light = LAMP_G;
      MAIN_Y:  main_light = LAMP_Y;
      SIDE_G:  side_light = LAMP_G;
      SIDE_Y:  side_light = LAMP_Y;
      default: ;
    endcase
  end

  assign phase = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl at default parameters; edge 0 is the reset edge.
module tb_traffic_light_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       side_car;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic [2:0] phase;
`ifdef TLC_PED_WALK_EN
  logic       ped_btn;
  logic       ped_walk;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  traffic_light_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .side_car  (side_car),
`ifdef TLC_PED_WALK_EN
    .ped_btn   (ped_btn),
    .ped_walk  (ped_walk),
`endif
    .main_light(main_light),
    .side_light(side_light),
    .phase     (phase)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at edge %0d: got %0h expected %0h", tag, cyc, actual, expected);
    end
  endtask

  // Inputs set here are sampled by the next rising edge; outputs are read 1 time unit after it.
  task automatic applyStimulus(input logic rst, input logic car);
    rst_n    = rst;
    side_car = car;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0);
    cyc = 0;
  endtask

  function automatic logic [5:0] expLamps(input int p);
    case (p)
      0:       return {3'b001, 3'b100};
      1:       return {3'b010, 3'b100};
      3:       return {3'b100, 3'b001};
      4:       return {3'b100, 3'b010};
      default: return {3'b100, 3'b100};
    endcase
  endfunction

  // Hand timeline for a request latched early: MAIN_Y 8, RED_1 11, SIDE_G 12, SIDE_Y 17, RED_2 20, MAIN_G 21.
  function automatic int expSingle(input int e);
    if (e < 8)  return 0;
    if (e < 11) return 1;
    if (e < 12) return 2;
    if (e < 17) return 3;
    if (e < 20) return 4;
    if (e < 21) return 5;
    return 0;
  endfunction

  task automatic checkState(input string tag, input int p);
    checkOutput({tag, "_phase"}, 32'(phase), 32'(p));
    checkOutput({tag, "_lamps"}, 32'({main_light, side_light}), 32'(expLamps(p)));
`ifdef TLC_PED_WALK_EN
    checkOutput({tag, "_walk"}, 32'(ped_walk), 32'(p == 3));
`endif
  endtask

  initial begin
`ifdef TLC_PED_WALK_EN
    ped_btn = 1'b0;
`endif
    rst_n    = 1'b0;
    side_car = 1'b0;

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1);
      checkState("in_reset", 0);
    end
    cyc = 0;
    for (int e = 1; e <= 9; e++) begin
      applyStimulus(1'b1, e <= 2);
      checkState("release", (e < 8) ? 0 : 1);
    end

    doReset();
    for (int e = 1; e <= 24; e++) begin
      applyStimulus(1'b1, e == 2);
      checkState("single", expSingle(e));
    end
    for (int e = 0; e < 100; e++) begin
      applyStimulus(1'b1, 1'b0);
      checkState("idle", 0);
    end

    doReset();
    for (int e = 1; e <= 46; e++) begin
      applyStimulus(1'b1, e == 40);
      checkState("late", (e < 43) ? 0 : ((e < 46) ? 1 : 2));
    end

    doReset();
    for (int e = 1; e <= 30; e++) begin
      applyStimulus(1'b1, (e == 2) || (e == 18));
      checkState("rerequest", (e <= 20) ? expSingle(e) : ((e < 29) ? 0 : 1));
    end

    doReset();
    for (int e = 1; e <= 13; e++) begin
      applyStimulus(1'b1, (e == 2) || (e == 11));
      checkState("pre_midreset", expSingle(e));
    end
    applyStimulus(1'b0, 1'b0);
    checkState("midreset", 0);
    cyc = 0;
    for (int e = 1; e <= 12; e++) begin
      applyStimulus(1'b1, 1'b0);
      checkState("post_midreset", 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
